// File: rtl/divider_fsm_pkg.sv
// Shared types and helpers for the multi-cycle unsigned divider.
package divider_fsm_pkg;

    // Control FSM: waiting for a start, or stepping through quotient bits
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Step counter width, $clog2(width), never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/divider_fsm.sv
// Multi-cycle unsigned divider: one quotient bit per enabled clock, or a
// behavioural reference datapath sharing the same control FSM and timing.
module divider_fsm
    import divider_fsm_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter bit ABSTRACT_MODEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_begin,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    logic w_start;
    logic w_step;
    logic w_last;

    // Both datapaths key off these, so handshake timing is mode-independent
    assign w_start = i_cg && (r_state == IDLE) && i_begin;
    assign w_step  = i_cg && (r_state == BUSY);
    assign w_last  = w_step && (r_cnt == LAST);

    assign o_busy      = (r_state == BUSY);
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

    // Control FSM, step counter and done pulse; everything holds while i_cg=0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (i_cg) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_begin) begin
                        r_state <= BUSY;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (r_cnt == LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (ABSTRACT_MODEL) begin : g_abstract
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            // Hold operands, produce / and % at the final step
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_quo <= '0;
                    r_rem <= '0;
                end else begin
                    if (w_start) begin
                        r_a <= i_dividend;
                        r_b <= i_divisor;
                    end
                    if (w_last) begin
                        // Match what the restoring datapath yields for /0
                        if (r_b == '0) begin
                            r_quo <= '1;
                            r_rem <= r_a;
                        end else begin
                            r_quo <= r_a / r_b;
                            r_rem <= r_a % r_b;
                        end
                    end
                end
            end
        end else begin : g_restoring
            // r_dvd shifts dividend bits out of the top while quotient bits
            // shift in at the bottom, so after WIDTH steps it holds the quotient.
            logic [WIDTH-1:0] r_dvd;
            logic [WIDTH-1:0] r_dsr;
            logic [WIDTH-1:0] r_prem;
            logic [WIDTH:0]   w_trial;
            logic             w_qbit;
            logic [WIDTH-1:0] w_rem_nxt;
            logic [WIDTH-1:0] w_quo_nxt;

            assign w_trial   = {r_prem, r_dvd[WIDTH-1]};
            assign w_qbit    = (w_trial >= {1'b0, r_dsr});
            // Remainder stays below the divisor, so the low WIDTH bits suffice
            assign w_rem_nxt = w_trial[WIDTH-1:0] - (w_qbit ? r_dsr : '0);
            assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};

            // One restoring step per enabled BUSY cycle; results load on the last
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_dvd  <= '0;
                    r_dsr  <= '0;
                    r_prem <= '0;
                    r_quo  <= '0;
                    r_rem  <= '0;
                end else begin
                    if (w_start) begin
                        r_dvd  <= i_dividend;
                        r_dsr  <= i_divisor;
                        r_prem <= '0;
                    end else if (w_step) begin
                        r_dvd  <= w_quo_nxt;
                        r_prem <= w_rem_nxt;
                    end
                    if (w_last) begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_divider_fsm.sv
// Bench: restoring and abstract dividers side by side against a behavioural
// model, with directed literal cases and a randomized soak.
module tb_divider_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cg  = 1'b1;
    logic         beg = 1'b0;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dsr = '0;

    logic         busy0, done0, busy1, done1;
    logic [W-1:0] q0, r0, q1, r1;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    divider_fsm #(.WIDTH(W), .ABSTRACT_MODEL(1'b0)) u_rest (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_begin(beg),
        .i_dividend(dvd), .i_divisor(dsr),
        .o_busy(busy0), .o_done(done0), .o_quotient(q0), .o_remainder(r0)
    );

    divider_fsm #(.WIDTH(W), .ABSTRACT_MODEL(1'b1)) u_abs (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_begin(beg),
        .i_dividend(dvd), .i_divisor(dsr),
        .o_busy(busy1), .o_done(done1), .o_quotient(q1), .o_remainder(r1)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    // Behavioural model: a countdown of enabled cycles, then plain / and %
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, pa = '0, pb = '0;
    int           m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_q = '0; m_r = '0; m_left = 0;
        end else if (cg) begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (pb == 0) begin m_q = '1; m_r = pa; end
                    else begin m_q = pa / pb; m_r = pa % pb; end
                end
            end else if (beg) begin
                m_busy = 1'b1; m_left = W; pa = dvd; pb = dsr;
            end
        end
    end

    // Every cycle: both implementations against the model
    always @(negedge clk) begin
        chk("busy_rest", busy0, m_busy);
        chk("done_rest", done0, m_done);
        chk("quo_rest",  q0,    m_q);
        chk("rem_rest",  r0,    m_r);
        chk("busy_abs",  busy1, m_busy);
        chk("done_abs",  done1, m_done);
        chk("quo_abs",   q1,    m_q);
        chk("rem_abs",   r1,    m_r);
    end

    // One directed division with literal expectations; optional gating/poke
    task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int eq, input int er, input int ebusy,
                       input int gate_at, input bit poke);
        int nb, nd;
        @(posedge clk); #1;
        beg = 1'b1; dvd = a; dsr = b;
        @(posedge clk); #1;
        beg = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == gate_at)     cg = 1'b0;
            if (c == gate_at + 3) cg = 1'b1;
            if (poke && c == 2) begin beg = 1'b1; dvd = W'($urandom); dsr = W'($urandom); end
            if (poke && c == 4) beg = 1'b0;
            @(negedge clk);
            nb += int'(busy0);
            nd += int'(done0);
            @(posedge clk); #1;
        end
        chk({nm, "_busy_cycles"}, nb, ebusy);
        chk({nm, "_done_pulses"}, nd, 1);
        chk({nm, "_q_rest"}, q0, eq);
        chk({nm, "_r_rest"}, r0, er);
        chk({nm, "_q_abs"},  q1, eq);
        chk({nm, "_r_abs"},  r1, er);
        chk({nm, "_q_model"}, m_q, eq);
    endtask

    initial begin
        int nd;
        @(posedge clk); #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_q",    q0,    0);
        chk("rst_r",    r1,    0);
        @(posedge clk); #1;
        rst = 1'b0;

        run("d100_7",   8'd100, 8'd7,   14,  2,   8, -10, 1'b0);
        run("d255_1",   8'd255, 8'd1,   255, 0,   8, -10, 1'b0);
        run("d0_9",     8'd0,   8'd9,   0,   0,   8, -10, 1'b0);
        run("d7_200",   8'd7,   8'd200, 0,   7,   8, -10, 1'b0);
        run("d255_255", 8'd255, 8'd255, 1,   0,   8, -10, 1'b0);
        run("d5_0",     8'd5,   8'd0,   255, 5,   8, -10, 1'b0);
        run("poke",     8'd200, 8'd3,   66,  2,   8, -10, 1'b1);
        run("gated",    8'd100, 8'd7,   14,  2,  11,   2, 1'b0);

        // Abort mid-division: outputs clear at once, no done afterwards
        @(posedge clk); #1;
        beg = 1'b1; dvd = 8'd77; dsr = 8'd5;
        @(posedge clk); #1;
        beg = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_q",    q0,    0);
        chk("abort_r",    r1,    0);
        @(posedge clk); #1;
        // Start in the first enabled cycle after reset release
        rst = 1'b0; beg = 1'b1; dvd = 8'd9; dsr = 8'd2;
        @(posedge clk); #1;
        beg = 1'b0;
        chk("post_rst_start", busy0, 1);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            nd += int'(done0);
        end
        chk("post_rst_done", nd, 1);
        chk("post_rst_q", q0, 4);
        chk("post_rst_r", r0, 1);

        // Randomized soak: random starts, gating, operands and rare resets
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 1999) == 0);
            cg  = ($urandom_range(0, 7) != 0);
            beg = ($urandom_range(0, 3) != 0);
            dvd = W'($urandom);
            case ($urandom_range(0, 3))
                0:       dsr = '0;
                1:       dsr = W'($urandom_range(1, 15));
                default: dsr = W'($urandom);
            endcase
        end
        @(posedge clk); #1;
        rst = 1'b0; cg = 1'b1; beg = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
